// File: rtl/multiplier_256bits_v13_if.sv
// Purpose: operand/result bundle for the 256x256 pipelined multiplier.
// Latency: none, wiring only.
// Backpressure: none; valid flags only, so the consumer must take every result.
//
// Signals:
//   in_valid  - A/B are sampled on the rising edge where this is high
//   A, B      - unsigned WIDTH-bit operands
//   out_valid - product carries the result of the pair accepted 2 edges earlier
//   product   - unsigned 2*WIDTH-bit full-precision product
interface multiplier_256bits_v13_if #(
    parameter int WIDTH = 256
);
    logic                   in_valid;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic                   out_valid;
    logic [2*WIDTH-1:0]     product;

    // Operand source side.
    modport master (
        output in_valid,
        output A,
        output B,
        input  out_valid,
        input  product
    );

    // Multiplier side.
    modport slave (
        input  in_valid,
        input  A,
        input  B,
        output out_valid,
        output product
    );
endinterface

// File: rtl/multiplier_256bits_v13.sv
// Purpose: unsigned 256x256 -> 512 multiplier built from 64x64 limb partial products.
// Latency: 2 cycles from the accepting edge to out_valid/product; one pair per cycle.
// Backpressure: none; results are presented for exactly one cycle and never stall.
//
// Ports:
//   clk   - single clock, rising-edge
//   rst_n - asynchronous active-low reset, clears every pipeline register
//   bus   - slave modport: in_valid/A/B in, out_valid/product out
module multiplier_256bits_v13 #(
    parameter int WIDTH = 256,
    parameter int LIMB  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multiplier_256bits_v13_if.slave     bus
);

    localparam int NL = WIDTH / LIMB;   // limbs per operand
    localparam int PW = 2 * LIMB;       // partial-product width
    localparam int OW = 2 * WIDTH;      // product width

    // Stage 1: limb partial products pp[i][j] = A limb i * B limb j.
    logic [PW-1:0] pp [NL][NL];
    logic          v1;

    // Stage 2 combinational reduction input.
    logic [OW-1:0] sum;

    // Stage 1 register. The partial products only load on an accepted pair so
    // that idle cycles leave the array (and hence the reduction) untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) begin
                for (int j = 0; j < NL; j++) begin
                    pp[i][j] <= '0;
                end
            end
            v1 <= 1'b0;
        end else begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < NL; i++) begin
                    for (int j = 0; j < NL; j++) begin
                        pp[i][j] <= PW'(bus.A[i*LIMB +: LIMB]) * PW'(bus.B[j*LIMB +: LIMB]);
                    end
                end
            end
        end
    end

    // Reduction: each partial product sits at limb offset i+j. Accumulating at
    // the full output width lets carries ripple across all 512 bits, so the
    // all-ones case is exact.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < NL; j++) begin
                sum = sum + (OW'(pp[i][j]) << (LIMB * (i + j)));
            end
        end
    end

    // Stage 2 register. product only updates for a valid stage-1 entry so the
    // last result stays visible after out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.product   <= '0;
        end else begin
            bus.out_valid <= v1;
            if (v1) begin
                bus.product <= sum;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_256bits_v13.sv
// Purpose: scoreboard bench for the 256x256 pipelined multiplier.
// Latency: expects each accepted pair back 2 edges later, in order.
// Backpressure: none; every out_valid cycle must match the head of the queue.
module tb_multiplier_256bits_v13;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multiplier_256bits_v13_if #(.WIDTH(256)) bus ();

    multiplier_256bits_v13 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int in_cnt      = 0;
    int out_cnt     = 0;

    logic [511:0] sb [$];

    // Hand-derived directed operands and products.
    localparam logic [255:0] A1 = 256'h5829EC10;
    localparam logic [255:0] B1 = 256'h123BBBCF00000000;
    localparam logic [511:0] E1 = 512'd452476455797231856 << 32;
    localparam logic [255:0] A2 = 256'h3489BE8F00000000;
    localparam logic [255:0] B2 = 256'hFFFFFFFF;
    localparam logic [511:0] E2 = 512'h3489BE8ECB76417100000000;
    localparam logic [255:0] AM = {256{1'b1}};
    localparam logic [511:0] EM = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    localparam logic [255:0] A4 = 256'hAB5BAFFF00000FD3;
    localparam logic [255:0] B4 = 256'hFFF1001000000000;
    localparam logic [255:0] BX = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_CAFEF00D;

    function automatic logic [511:0] ref_mul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] za;
        logic [511:0] zb;
        za = {256'b0, a};
        zb = {256'b0, b};
        return za * zb;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor_loop();
        logic [511:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 512'(bus.out_valid), 512'd0);
                end else begin
                    exp = sb.pop_front();
                    check("product", bus.product, exp);
                    out_cnt++;
                end
            end
        end
    endtask

    task automatic watchdog();
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", sb.size());
        $fatal(1, "timeout");
    endtask

    // Present one pair for the coming edge and record its expected product.
    task automatic put(input logic [255:0] a, input logic [255:0] b, input logic [511:0] e);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        in_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int w;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;

        fork
            monitor_loop();
            watchdog();
        join_none

        #2;
        check("reset_product", bus.product, 512'd0);
        check("reset_out_valid", 512'(bus.out_valid), 512'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Isolated vectors, then confirm out_valid drops and product holds.
        put(A1, B1, E1);
        idle(3);
        check("idle_out_valid", 512'(bus.out_valid), 512'd0);
        check("idle_product_hold", bus.product, E1);

        put(A2, B2, E2);
        idle(1);
        put(AM, AM, EM);
        idle(1);
        put(256'd0, BX, 512'd0);
        idle(1);
        put(256'd1, BX, {256'b0, BX});
        idle(3);
        check("hold_after_one_x", bus.product, {256'b0, BX});

        // Back-to-back stream.
        put(A1, B1, E1);
        put(A2, B2, E2);
        put(AM, AM, EM);
        put(A4, B4, ref_mul(A4, B4));
        idle(4);
        check("stream_drained", 512'(sb.size()), 512'd0);

        // Reset with three pairs in flight; first result is already on the
        // outputs, so both must clear asynchronously.
        put(A2, B2, E2);
        put(AM, AM, EM);
        put(A1, B1, E1);
        check("pre_reset_out_valid", 512'(bus.out_valid), 512'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_product", bus.product, 512'd0);
        check("midreset_out_valid", 512'(bus.out_valid), 512'd0);
        sb.delete();
        in_cnt  = 0;
        out_cnt = 0;

        // in_valid high while reset is held: must not be captured.
        bus.A        = AM;
        bus.B        = AM;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("post_reset_out_valid", 512'(bus.out_valid), 512'd0);
            @(posedge clk);
            #1;
        end
        check("post_reset_product", bus.product, 512'd0);

        // Random regression with gaps.
        for (int n = 0; n < 10000; n++) begin
            logic [255:0] ra;
            logic [255:0] rb;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            ra = rnd256();
            rb = rnd256();
            put(ra, rb, ref_mul(ra, rb));
        end
        idle(4);

        w = 0;
        while (sb.size() != 0 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("final_drain", 512'(sb.size()), 512'd0);
        check("valid_count", 512'(out_cnt), 512'(in_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
